booth_seq_multiplier: RTL and testbench

//  Iterative radix-4 (modified) Booth multiplier with valid/ready handshakes.

---
 rtl/booth_seq_multiplier.sv | 187 ++++++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// ----------------------------------------------------------------------------
// booth_seq_multiplier
// Iterative radix-4 (modified) Booth multiplier with valid/ready handshakes.
// One Booth digit is retired per clock. A per-transaction flag selects
// two's-complement or unsigned operands. The product is exact at 2*WIDTH bits.
//
// Operation
//   IDLE : operands are captured and extended. The multiplicand is extended to
//          2*WIDTH+2 bits. The multiplier is extended to 2*NSTEP bits, and then
//          a zero LSB is appended.
//   CALC : NSTEP accumulate steps, then one cycle that publishes the product.
//          On the first edge the product register is written; on that same
//          edge the state moves to DONE.
//   DONE : the product is held until out_ready is seen.
//
// Instead of a barrel shifter, the multiplicand shifts left by two and the
// multiplier shifts right by two on every step. The digit triplet is therefore
// always found in the low three bits of the multiplier register.
// ----------------------------------------------------------------------------
module booth_seq_multiplier #(
   parameter int WIDTH = 8                       // operand width, must be >= 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 busy
);

   // Booth digits per operation
   localparam int NSTEP = (WIDTH / 2) + 1;
   // Accumulator / multiplicand width
   localparam int AW    = 2 * WIDTH + 2;
   // Multiplier register width (extended operand plus appended zero LSB)
   localparam int BW    = 2 * NSTEP + 1;
   // Step counter has to reach NSTEP (the publish cycle)
   localparam int CW    = $clog2(NSTEP + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [AW-1:0]        a_q, a_d;        // multiplicand, pre-shifted by 2k
   logic [BW-1:0]        b_q, b_d;        // multiplier, consumed two bits/step
   logic [AW-1:0]        acc_q, acc_d;    // running partial sum
   logic [CW-1:0]        step_q, step_d;  // Booth step index
   logic [2*WIDTH-1:0]   product_q, product_d;

   // Operand extension. In unsigned mode the extension bits are zero, so the
   // top operand bit is never read as a sign.
   logic                 a_ext_bit;
   logic                 b_ext_bit;
   logic [AW-1:0]        a_ext;
   logic [BW-1:0]        b_ext;

   assign a_ext_bit = in_signed & in_a[WIDTH-1];
   assign b_ext_bit = in_signed & in_b[WIDTH-1];
   assign a_ext     = {{(AW - WIDTH){a_ext_bit}}, in_a};
   assign b_ext     = {{(2 * NSTEP - WIDTH){b_ext_bit}}, in_b, 1'b0};

   logic [2:0]           triplet;
   logic [AW-1:0]        term;

   assign triplet = b_q[2:0];

   // ------------------------------------------------------------------------
   // FSM state register
   // NOTE: sequential state is updated only with non-blocking assignments.
   //       This lets every flop sample the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state decode
   // NOTE: every combinational output is given a default before the case
   //       statement. Otherwise a path that does not assign it infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CALC;
            end
         end
         CALC: begin
            if (step_q == LAST_STEP) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs, decoded from registered state only
   always_comb begin
      in_ready    = (state_q == IDLE);
      out_valid   = (state_q == DONE);
      busy        = (state_q == CALC) || (state_q == DONE);
      out_product = product_q;
   end

   // ------------------------------------------------------------------------
   // Booth digit selection: 0, +A, +2A, -2A or -A from the current triplet
   always_comb begin
      term = '0;
      case (triplet)
         3'b001, 3'b010: term = a_q;
         3'b011:         term = a_q << 1;
         3'b100:         term = -(a_q << 1);
         3'b101, 3'b110: term = -a_q;
         default:        term = '0;
      endcase
   end

   // Datapath next-state: capture, accumulate, publish
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      step_d    = step_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d    = a_ext;
               b_d    = b_ext;
               acc_d  = '0;
               step_d = '0;
            end
         end
         CALC: begin
            if (step_q == LAST_STEP) begin
               // Only a finished sum ever reaches the output register
               product_d = acc_q[2*WIDTH-1:0];
            end else begin
               acc_d  = acc_q + term;
               a_d    = a_q << 2;
               b_d    = b_q >> 2;
               step_d = step_q + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers. Reset clears all of them, so an aborted operation
   // leaves no residue behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         step_q    <= '0;
         product_q <= '0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         step_q    <= step_d;
         product_q <= product_d;
      end
   end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_booth_seq_multiplier
// Exercises three instances: WIDTH = 8, 5 and 16. A shared reset and a shared
// clock drive all of them.
// Expected products come from two sources:
//   - the constants for the directed cases;
//   - plain integer multiplication of the extended operand values for the
//     randomized transactions.
// Inputs are driven on the falling edge, and outputs are sampled there as well.
// ----------------------------------------------------------------------------
module tb_booth_seq_multiplier;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  in_valid_s;
   logic [2:0]  in_ready_s;
   logic [2:0]  in_signed_s;
   logic [2:0]  out_valid_s;
   logic [2:0]  out_ready_s;
   logic [2:0]  busy_s;
   logic [15:0] a_s [3];
   logic [15:0] b_s [3];
   logic [15:0] prod8;
   logic [9:0]  prod5;
   logic [31:0] prod16;

   int checks = 0;
   int errors = 0;

   booth_seq_multiplier #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .in_a(a_s[0][7:0]), .in_b(b_s[0][7:0]), .in_signed(in_signed_s[0]),
      .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
      .out_product(prod8), .busy(busy_s[0])
   );

   booth_seq_multiplier #(.WIDTH(5)) u_dut5 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .in_a(a_s[1][4:0]), .in_b(b_s[1][4:0]), .in_signed(in_signed_s[1]),
      .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
      .out_product(prod5), .busy(busy_s[1])
   );

   booth_seq_multiplier #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
      .in_a(a_s[2]), .in_b(b_s[2]), .in_signed(in_signed_s[2]),
      .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
      .out_product(prod16), .busy(busy_s[2])
   );

   // Operand width of instance idx
   function automatic int width_of(input int idx);
      case (idx)
         0:       return 8;
         1:       return 5;
         default: return 16;
      endcase
   endfunction

   // Product output of instance idx, zero-extended to 32 bits
   function automatic logic [31:0] prod_of(input int idx);
      case (idx)
         0:       return {16'b0, prod8};
         1:       return {22'b0, prod5};
         default: return prod16;
      endcase
   endfunction

   // Reference: interpret operands as signed or unsigned, multiply, then keep
   // 2*w bits
   function automatic logic [63:0] ref_prod(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic sgn);
      longint av, bv, p;
      logic [63:0] r;
      av = longint'({48'b0, a});
      bv = longint'({48'b0, b});
      if (sgn && a[w-1]) av = av - (longint'(1) << w);
      if (sgn && b[w-1]) bv = bv - (longint'(1) << w);
      p = av * bv;
      r = p;
      return r & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // A single transaction. The task is entered on a falling edge with the
   // instance in IDLE, and it leaves on a falling edge with the instance back
   // in IDLE.
   task automatic do_txn(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic sgn, input int stall_in, input int stall_out,
                         input logic [63:0] exp, input string name);
      int w, nstep, lat;
      logic [31:0] held;
      w     = width_of(idx);
      nstep = w / 2 + 1;
      in_valid_s[idx] = 1'b0;
      repeat (stall_in) @(negedge clk);
      checks++;
      if (in_ready_s[idx] !== 1'b1) begin
         errors++;
         $display("FAIL %s idle_in_ready: got %b expected 1", name, in_ready_s[idx]);
      end
      a_s[idx]         = a;
      b_s[idx]         = b;
      in_signed_s[idx] = sgn;
      in_valid_s[idx]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      // Junk on the inputs while busy must not disturb the operation
      in_valid_s[idx]  = 1'($urandom_range(0, 1));
      a_s[idx]         = 16'($urandom);
      b_s[idx]         = 16'($urandom);
      in_signed_s[idx] = ~sgn;
      checks++;
      if ({busy_s[idx], in_ready_s[idx], out_valid_s[idx]} !== 3'b100) begin
         errors++;
         $display("FAIL %s calc_flags: got busy/in_ready/out_valid=%b%b%b expected 100",
                  name, busy_s[idx], in_ready_s[idx], out_valid_s[idx]);
      end
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid_s[idx] === 1'b1) break;
      end
      in_valid_s[idx] = 1'b0;
      checks++;
      if (lat != nstep + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d edges expected %0d", name, lat, nstep + 1);
      end
      checks++;
      if ({32'b0, prod_of(idx)} !== exp) begin
         errors++;
         $display("FAIL %s product: got %h expected %h (a=%h b=%h signed=%b w=%0d)",
                  name, prod_of(idx), exp[31:0], a, b, sgn, w);
      end
      held = prod_of(idx);
      repeat (stall_out) begin
         @(negedge clk);
         checks++;
         if (out_valid_s[idx] !== 1'b1 || in_ready_s[idx] !== 1'b0 ||
             prod_of(idx) !== held) begin
            errors++;
            $display("FAIL %s hold: got out_valid=%b in_ready=%b product=%h expected 1 0 %h",
                     name, out_valid_s[idx], in_ready_s[idx], prod_of(idx), held);
         end
      end
      out_ready_s[idx] = 1'b1;
      @(negedge clk);
      out_ready_s[idx] = 1'b0;
      checks++;
      if (out_valid_s[idx] !== 1'b0 || in_ready_s[idx] !== 1'b1 || busy_s[idx] !== 1'b0) begin
         errors++;
         $display("FAIL %s release: got out_valid=%b in_ready=%b busy=%b expected 0 1 0",
                  name, out_valid_s[idx], in_ready_s[idx], busy_s[idx]);
      end
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      in_valid_s  = '0;
      in_signed_s = '0;
      out_ready_s = '0;
      for (int i = 0; i < 3; i++) begin
         a_s[i] = '0;
         b_s[i] = '0;
      end
      #3;
      checks++;
      if (in_ready_s !== 3'b111 || out_valid_s !== 3'b000 || busy_s !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got in_ready=%b out_valid=%b busy=%b expected 111 000 000",
                  in_ready_s, out_valid_s, busy_s);
      end
      checks++;
      if (prod8 !== 16'h0 || prod5 !== 10'h0 || prod16 !== 32'h0) begin
         errors++;
         $display("FAIL reset_product: got %h %h %h expected zeros", prod8, prod5, prod16);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready_s !== 3'b111 || busy_s !== 3'b000) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b busy=%b expected 111 000",
                  in_ready_s, busy_s);
      end
   endtask

   task automatic test_directed();
      do_txn(0, 16'h00FC, 16'h0003, 1'b1, 0, 0, 64'hFFF4, "neg4x3");
      do_txn(0, 16'h00FF, 16'h00FF, 1'b0, 0, 0, 64'hFE01, "u255x255");
      do_txn(0, 16'h00FF, 16'h00FF, 1'b1, 0, 0, 64'h0001, "s255x255");
      do_txn(0, 16'h0080, 16'h0080, 1'b1, 1, 0, 64'h4000, "s_min_x_min");
      do_txn(0, 16'h007F, 16'h0080, 1'b1, 0, 0, 64'hC080, "s_max_x_min");
      do_txn(1, 16'h0010, 16'h0010, 1'b1, 0, 0, 64'h100, "w5_min_x_min");
      do_txn(1, 16'h001F, 16'h001F, 1'b0, 0, 0, 64'h3C1, "w5_u31x31");
      do_txn(2, 16'h8000, 16'h8000, 1'b1, 0, 0, 64'h40000000, "w16_min_x_min");
      do_txn(2, 16'hFFFF, 16'hFFFF, 1'b0, 0, 0, 64'hFFFE0001, "w16_umax");
   endtask

   task automatic test_backpressure();
      do_txn(0, 16'h0012, 16'h0034, 1'b0, 0, 10, 64'h03A8, "backpressure");
      do_txn(0, 16'h00F6, 16'h0005, 1'b1, 0, 0, 64'hFFCE, "after_backpressure");
   endtask

   task automatic test_reset_mid_calc();
      a_s[0]         = 16'h0064;
      b_s[0]         = 16'h009C;
      in_signed_s[0] = 1'b1;
      in_valid_s[0]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_s[0]  = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0 ||
          prod8 !== 16'h0) begin
         errors++;
         $display("FAIL mid_calc_reset: got in_ready=%b out_valid=%b busy=%b product=%h expected 1 0 0 0000",
                  in_ready_s[0], out_valid_s[0], busy_s[0], prod8);
      end
      @(negedge clk);
      rst = 1'b0;
      do_txn(0, 16'h0007, 16'h00F9, 1'b1, 0, 0, 64'hFFCF, "after_reset_7xm7");
   endtask

   task automatic test_random(input int idx, input int n);
      int w;
      logic [15:0] mask, a, b;
      logic sgn;
      w    = width_of(idx);
      mask = 16'((32'd1 << w) - 32'd1);
      for (int t = 0; t < n; t++) begin
         a   = 16'($urandom) & mask;
         b   = 16'($urandom) & mask;
         sgn = 1'($urandom_range(0, 1));
         do_txn(idx, a, b, sgn, $urandom_range(0, 3), $urandom_range(0, 3),
                ref_prod(w, a, b, sgn), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_calc();
      test_random(0, 400);
      test_random(1, 400);
      test_random(2, 400);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
